// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state
// encoding, word geometry and header width.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHK    = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int HDR_W      = 16;

endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes big-endian (first byte ends up in [31:24]) and
// flags the 4th byte of a word. The complete word is presented on `word`
// in the same cycle as word_full so the caller can capture it directly.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      acc;

    assign word      = {acc[23:0], byte_in};
    assign word_full = shift && (cnt == CNT_W'(WORD_BYTES - 1));

    // Byte counter wraps naturally after a full word; clear realigns on a new load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (clear) begin
            cnt <= '0;
            acc <= '0;
        end else if (shift) begin
            cnt <= cnt + 1'b1;
            acc <= {acc[23:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory and releases the core.
// Stream: 16-bit big-endian word count N, then N big-endian words.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: a trailing byte equal to
// the XOR of all data bytes is checked before the core is released.
// Handshake: a byte moves only on a rising edge where in_valid && in_ready;
// in_ready depends on state alone, so in_valid may toggle freely.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        core_run,
    output state_t      state
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CHK;
    logic [7:0] chk_q;
`else
    localparam state_t AFTER_LOAD = DONE;
`endif

    state_t           state_q, state_d;
    logic [HDR_W-1:0] count_q;
    logic [HDR_W-1:0] word_idx;
    logic             accept, can_start, last_word, word_full;
    logic [HDR_W-1:0] hdr_n;
    logic [31:0]      asm_word;

    assign can_start = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign accept    = in_valid && in_ready;
    assign hdr_n     = {count_q[HDR_W-1:8], in_data};
    assign last_word = (word_idx == count_q - 1'b1);

    assign state    = state_q;
    assign wr_en    = (state_q == WRITE);
    assign busy     = !(state_q == IDLE || state_q == DONE || state_q == ERR);
    assign done     = (state_q == DONE);
    assign core_run = (state_q == DONE);
    assign error    = (state_q == ERR);

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (can_start),
        .shift     (accept && state_q == DATA),
        .byte_in   (in_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    // Byte acceptance is limited to the states that consume stream bytes.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            HDR_HI, HDR_LO, DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:                  in_ready = 1'b1;
`endif
            default:              in_ready = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = HDR_HI;
            HDR_HI:          if (accept) state_d = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if ({16'd0, hdr_n} > 32'(DEPTH)) state_d = ERR;
                    else if (hdr_n == '0)           state_d = AFTER_LOAD;
                    else                            state_d = DATA;
                end
            end
            DATA:            if (word_full) state_d = WRITE;
            WRITE:           state_d = last_word ? AFTER_LOAD : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:             if (accept) state_d = (in_data == chk_q) ? DONE : ERR;
`endif
            default:         state_d = ERR;
        endcase
    end

    // Datapath: header count, word index, held write address/data, checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            word_idx <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            if (can_start) begin
                count_q  <= '0;
                word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk_q    <= '0;
`endif
            end
            if (state_q == HDR_HI && accept) count_q[HDR_W-1:8] <= in_data;
            if (state_q == HDR_LO && accept) count_q[7:0]       <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state_q == DATA && accept) chk_q <= chk_q ^ in_data;
`endif
            if (word_full) begin
                wr_addr <= {14'd0, word_idx, 2'b00};
                wr_data <= asm_word;
            end
            if (state_q == WRITE) word_idx <= word_idx + 1'b1;
        end
    end

endmodule
